// File: rtl/memory_responder.sv
// Word-addressed synchronous RAM responder with fixed wait states and 4-phase done handshake.
// Latency: memDone/mDataOut update on edge E0+WAIT_STATES+1 after request sampling (E0 for Read&Write error).
// Backpressure: holds DONE until both strobes drop; held strobes never retrigger an access.
module memory_responder #(
   parameter int ADDR_WIDTH  = 9,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  Read,
   input  logic                  Write,
   input  logic [ADDR_WIDTH-1:0] mAddr,
   input  logic [31:0]           wrData,
   output logic [31:0]           mDataOut,
   output logic                  memDone,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS, ST_DONE} state_t;

   // Last counter value spent in WAIT; unused when there are no wait states.
   localparam logic [3:0] CNT_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   logic [31:0]           ram [2**ADDR_WIDTH];

   state_t                state_q,  state_d;
   logic [3:0]            cnt_q,    cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
   logic [31:0]           data_q,   data_d;
   logic                  is_wr_q,  is_wr_d;
   logic [31:0]           dout_q,   dout_d;
   logic                  done_q,   done_d;
   logic                  err_q,    err_d;
   logic                  ram_we;

   // Next-state and output computation for the request sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      is_wr_d = is_wr_q;
      dout_d  = dout_q;
      done_d  = done_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (Read ^ Write) begin
               addr_d  = mAddr;
               data_d  = wrData;
               is_wr_d = Write;
               cnt_d   = 4'd0;
               state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
            end else if (Read && Write) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_ACCESS: begin
            if (!is_wr_q) begin
               dout_d = ram[addr_q];
            end
            done_d  = 1'b1;
            err_d   = 1'b0;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!Read && !Write) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A write only lands on a clean ACCESS edge; reset on that edge suppresses it.
   assign ram_we = (state_q == ST_ACCESS) && is_wr_q && !clr;

   // Sequencer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         data_q  <= '0;
         is_wr_q <= 1'b0;
         dout_q  <= 32'd0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         is_wr_q <= is_wr_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // RAM storage; contents survive reset.
   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram[addr_q] <= data_q;
      end
   end

   assign mDataOut = dout_q;
   assign memDone  = done_q;
   assign err      = err_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: WAIT_STATES=2 and WAIT_STATES=0 instances side by side.
// Directed scenarios followed by random transactions checked against an array model of RAM contents.
// Inputs driven 1ns after posedge, outputs sampled at the same point.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic [1:0]  clr;
   logic [1:0]  rd;
   logic [1:0]  wr;
   logic [8:0]  addr [2];
   logic [31:0] wdat [2];
   logic [31:0] dout [2];
   logic [1:0]  done;
   logic [1:0]  busy;
   logic [1:0]  err;

   int          vectors    = 0;
   int          miscompares = 0;

   // Reference model: what each instance's RAM should hold and what mDataOut should show.
   logic [31:0] mdl   [2][512];
   bit          known [2][512];
   logic [8:0]  klist [2][512];
   int          kn    [2];
   logic [31:0] exp_dout [2];
   int          ws [2];

   always #5 clk = ~clk;

   memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(2)) u_ws2 (
      .clk(clk), .clr(clr[0]), .Read(rd[0]), .Write(wr[0]),
      .mAddr(addr[0]), .wrData(wdat[0]),
      .mDataOut(dout[0]), .memDone(done[0]), .busy(busy[0]), .err(err[0])
   );

   memory_responder #(.ADDR_WIDTH(9), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .clr(clr[1]), .Read(rd[1]), .Write(wr[1]),
      .mAddr(addr[1]), .wrData(wdat[1]),
      .mDataOut(dout[1]), .memDone(done[1]), .busy(busy[1]), .err(err[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction on instance s, starting from IDLE and ending back in IDLE.
   task automatic access(input int s, input bit r, input bit w, input logic [8:0] a,
                         input logic [31:0] d, input bit perturb, input int hold);
      int n;
      bit ill;
      ill = r & w;
      rd[s] = r;  wr[s] = w;  addr[s] = a;  wdat[s] = d;
      tick();  // E0
      if (perturb && !ill) begin
         addr[s] = a + 9'd1;
         wdat[s] = ~d;
         rd[s]   = 1'b0;
         wr[s]   = 1'b0;
      end
      n = 0;
      while (!done[s] && n < 40) begin
         chk("busy_in_flight", busy[s], 1);
         tick();
         n++;
      end
      chk("done_latency", n, ill ? 0 : ws[s] + 1);
      if (!ill && w) begin
         mdl[s][a] = d;
         if (!known[s][a]) begin
            known[s][a] = 1'b1;
            klist[s][kn[s]] = a;
            kn[s]++;
         end
      end
      if (!ill && r) exp_dout[s] = mdl[s][a];
      chk("done_high", done[s], 1);
      chk("err_flag", err[s], ill);
      chk("busy_in_done", busy[s], 1);
      chk("read_data", dout[s], exp_dout[s]);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_done", done[s], 1);
         chk("hold_err", err[s], ill);
         chk("hold_data", dout[s], exp_dout[s]);
      end
      rd[s] = 1'b0;
      wr[s] = 1'b0;
      tick();
      chk("release_done", done[s], 0);
      chk("release_err", err[s], 0);
      chk("release_busy", busy[s], 0);
      chk("release_data", dout[s], exp_dout[s]);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdat;
      logic [8:0]  ra;
      int          op;
      bit          pt;
      int          hl;

      ws[0] = 2;  ws[1] = 0;
      kn[0] = 0;  kn[1] = 0;
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 512; i++) known[s][i] = 1'b0;
      clr = 2'b11;  rd = 2'b00;  wr = 2'b00;
      addr[0] = '0;  addr[1] = '0;  wdat[0] = '0;  wdat[1] = '0;

      // Reset state
      tick();  tick();
      for (int s = 0; s < 2; s++) begin
         chk("reset_done", done[s], 0);
         chk("reset_busy", busy[s], 0);
         chk("reset_err",  err[s],  0);
         chk("reset_data", dout[s], 0);
         exp_dout[s] = 32'd0;
      end
      clr = 2'b00;
      tick();

      // Write then read back
      access(0, 0, 1, 9'h055, 32'hDEADBEEF, 0, 0);
      access(0, 1, 0, 9'h055, 32'h0, 0, 0);

      // Capture stability: inputs change right after E0
      access(0, 0, 1, 9'h011, 32'h0BADF00D, 0, 0);
      access(0, 0, 1, 9'h010, 32'h12345678, 1, 0);
      access(0, 1, 0, 9'h010, 32'h0, 0, 0);
      access(0, 1, 0, 9'h011, 32'h0, 0, 0);

      // 4-phase hold: Read held 5 cycles past memDone
      access(0, 0, 1, 9'h020, 32'h5A5A1234, 0, 0);
      access(0, 1, 0, 9'h020, 32'h0, 0, 5);
      access(0, 1, 0, 9'h020, 32'h0, 0, 0);

      // Illegal request leaves RAM and mDataOut alone
      access(0, 1, 0, 9'h055, 32'h0, 0, 0);
      access(0, 1, 1, 9'h020, 32'hFFFF0000, 0, 0);
      access(0, 1, 0, 9'h020, 32'h0, 0, 0);

      // Reset in the 2nd WAIT cycle aborts a write
      access(0, 0, 1, 9'h100, 32'h0000000F, 0, 0);
      rd[0] = 1'b0;  wr[0] = 1'b1;  addr[0] = 9'h100;  wdat[0] = 32'hA5A5A5A5;
      tick();  // E0
      tick();  // now in 2nd WAIT cycle
      clr[0] = 1'b1;
      tick();
      exp_dout[0] = 32'd0;
      chk("midreset_done", done[0], 0);
      chk("midreset_busy", busy[0], 0);
      chk("midreset_data", dout[0], 0);
      clr[0] = 1'b0;  wr[0] = 1'b0;
      tick();
      access(0, 1, 0, 9'h100, 32'h0, 0, 0);

      // Reset on the ACCESS edge also suppresses the write
      rd[0] = 1'b0;  wr[0] = 1'b1;  addr[0] = 9'h100;  wdat[0] = 32'hCAFEF00D;
      tick();  // E0
      tick();
      tick();  // now in ACCESS
      clr[0] = 1'b1;
      tick();
      exp_dout[0] = 32'd0;
      chk("accreset_done", done[0], 0);
      chk("accreset_data", dout[0], 0);
      clr[0] = 1'b0;  wr[0] = 1'b0;
      tick();
      access(0, 1, 0, 9'h100, 32'h0, 0, 0);

      // Zero-wait instance: top address and address zero
      access(1, 0, 1, 9'h1FF, 32'h00000001, 0, 0);
      access(1, 1, 0, 9'h1FF, 32'h0, 0, 0);
      rdat = $urandom;
      access(1, 0, 1, 9'h000, rdat, 0, 0);
      access(1, 1, 0, 9'h000, 32'h0, 0, 0);

      // Random traffic on both instances
      for (int s = 0; s < 2; s++) begin
         for (int t = 0; t < 80; t++) begin
            op = $urandom_range(0, 9);
            pt = ($urandom_range(0, 3) == 0);
            hl = pt ? 0 : $urandom_range(0, 3);
            if (op == 0) begin
               ra = 9'($urandom);
               access(s, 1, 1, ra, $urandom, 0, hl);
            end else if (op <= 5) begin
               ra = klist[s][$urandom_range(0, kn[s] - 1)];
               access(s, 1, 0, ra, $urandom, pt, hl);
            end else begin
               ra = 9'($urandom);
               access(s, 0, 1, ra, $urandom, pt, hl);
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
